// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the fifo write arbiter.
package fifo_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int FIFO_WIDTH_DEF = 8;
    localparam int MAX_BURST_DEF  = 8;

    // IDLE: no owner, arbitrating. OWN: one producer holds the write port.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_select.sv
// Round-robin winner selection: first requester strictly after last_owner,
// wrapping from NUM_REQ-1 back to 0. Purely combinational.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [IDX_W-1:0]   winner_idx_o,
    output logic               any_o
);

    int cand;

    // Scan candidates in priority order starting just after the last owner.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path can leave one unassigned and infer a latch.
        winner_o     = '0;
        winner_idx_o = '0;
        any_o        = 1'b0;
        cand         = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_owner_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_o && req_i[cand[IDX_W-1:0]]) begin
                winner_o[cand[IDX_W-1:0]] = 1'b1;
                winner_idx_o              = cand[IDX_W-1:0];
                any_o                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arb.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// A granted producer keeps the port for a burst that ends on req_last or
// after MAX_BURST accepted words; one idle cycle separates bursts.
// Optional build macro FIFO_WRITE_ARB_STATS_EN adds the stall_cnt output.
module fifo_write_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_ack,
    output logic [NUM_REQ-1:0]                 grant,
    input  logic                               fifo_full,
    output logic                               fifo_write_en,
    output logic [FIFO_WIDTH-1:0]              fifo_data,
    output logic                               busy
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,
    output logic [31:0]                        stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [NUM_REQ-1:0]  rr_winner;
    logic [IDX_W-1:0]    rr_idx;
    logic                rr_any;
    logic                accept;
    logic                burst_end;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req_i        (req_valid),
        .last_owner_i (last_owner_q),
        .winner_o     (rr_winner),
        .winner_idx_o (rr_idx),
        .any_o        (rr_any)
    );

    // Write-port datapath: accept is gated by reset so nothing is written
    // while rst is low, even in the cycle before the state register clears.
    always_comb begin
        accept        = (state_q == OWN) && req_valid[owner_q] && !fifo_full && rst;
        burst_end     = req_last[owner_q] || (count_q == CNT_W'(MAX_BURST - 1));
        fifo_write_en = accept;
        req_ack       = accept ? grant_q : '0;
        fifo_data     = (state_q == OWN) ? req_data[owner_q] : '0;
        busy          = (state_q == OWN) && rst;
        grant         = grant_q;
    end

    // Next-state logic: arbitrate in IDLE, count and release in OWN.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        count_d      = count_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (rr_any) begin
                    state_d = OWN;
                    grant_d = rr_winner;
                    owner_d = rr_idx;
                end
            end
            OWN: begin
                if (accept) begin
                    if (burst_end) begin
                        state_d      = IDLE;
                        grant_d      = '0;
                        last_owner_d = owner_q;
                        count_d      = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset; producer 0 wins first.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking (<=) so every register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
        end
    end

`ifdef FIFO_WRITE_ARB_STATS_EN
    logic [31:0] stall_cnt_q;

    // Count OWN cycles where the owner has a word but the fifo is full; saturating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == OWN) && req_valid[owner_q] && fifo_full && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fifo_write_arb.md
FIFO_WRITE_ARB -- requirements
Module: fifo_write_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of producers sharing one FIFO write port (2..8).
REQ-002 Parameter FIFO_WIDTH, default 8: word width; equals the attached fifo's FIFO_WIDTH.
REQ-003 Parameter MAX_BURST, default 8: maximum words per grant (1..256).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous and active-low.
REQ-006 req_valid  in  NUM_REQ  per-producer word available.
REQ-007 req_data  in  NUM_REQ x FIFO_WIDTH  per-producer word, packed array indexed by producer.
REQ-008 req_last  in  NUM_REQ  per-producer marker: current word ends the burst.
REQ-009 req_ack  out  NUM_REQ  one-hot; word of that producer written this cycle.
REQ-010 grant  out  NUM_REQ  one-hot registered current owner; all-zero when idle.
REQ-011 fifo_full  in  1  full flag from the attached fifo.
REQ-012 fifo_write_en  out  1  drives the fifo write_en.
REQ-013 fifo_data  out  FIFO_WIDTH  drives the fifo data_in.
REQ-014 busy  out  1  high while in state OWN.

Function
REQ-015 The FSM SHALL have two states, IDLE and OWN.
- IDLE: if any req_valid is high, select the owner and enter OWN next cycle; otherwise stay.
- Arbitration latency: exactly 1 cycle from req_valid to grant.
REQ-016 Owner selection SHALL be round-robin: first requesting index strictly after last_owner, wrapping NUM_REQ-1 -> 0.
REQ-017 In OWN, accept = req_valid[g] & !fifo_full & rst.
- accept drives fifo_write_en, req_ack[g], and fifo_data = req_data[g], all combinationally in the same cycle.
REQ-018 When accept is low, fifo_write_en SHALL be 0 and req_ack SHALL be all-zero.
- fifo_data SHALL show req_data[g] in OWN and 0 in IDLE.
REQ-019 The burst counter (width clog2(MAX_BURST)+1) SHALL increment on each accept and clear on entering IDLE.
REQ-020 Release: on a cycle with accept & (req_last[g] | count == MAX_BURST-1), the FSM SHALL go to IDLE, update last_owner to g, and clear grant the next cycle.
REQ-021 If the owner drops req_valid without req_last, the FSM SHALL hold the grant (stall) with no write.
REQ-022 fifo_full high in OWN SHALL stall: no write, no ack, counter held, grant held.
REQ-023 Re-arbitration takes one IDLE cycle after release, so back-to-back bursts are separated by exactly one idle cycle.
REQ-024 req_valid on non-owners SHALL be ignored in OWN; their req_ack stays 0.

Reset
REQ-025 With rst low at a clock edge, the block SHALL enter IDLE with grant=0, count=0, and last_owner=NUM_REQ-1, so producer 0 wins first.
REQ-026 While rst is low, fifo_write_en, req_ack and busy SHALL be 0, including during a mid-burst reset; the aborted burst is not resumed.

Configuration
REQ-027 Macro FIFO_WRITE_ARB_STATS_EN, when defined, SHALL add output stall_cnt (32 bits).
- stall_cnt counts cycles in OWN with req_valid[g] & fifo_full.
- It saturates at all-ones and clears on reset.
REQ-028 Without FIFO_WRITE_ARB_STATS_EN, the port and its counter SHALL be absent, with no other behaviour change.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold the state enum typedef (IDLE, OWN) and the default constants NUM_REQ_DEF, MAX_BURST_DEF.
REQ-030 Round-robin selection SHALL be the sub-module rr_select.
- Inputs: request vector, last_owner.
- Outputs: one-hot winner, winner index, any.
- Purely combinational.
REQ-031 The verification bench SHALL instantiate fifo_write_arb driving a fifo (FIFO_DEPTH 32, FIFO_WIDTH 8).

Verification
REQ-032 Single producer: after reset, producer 0 sends 3 words 0xA0..0xA2 with req_last on 0xA2.
- grant=0001 one cycle after req_valid.
- 3 consecutive writes, then grant=0.
- FIFO reads back A0,A1,A2.
REQ-033 Contention: all 4 producers valid with endless bursts and no req_last.
- Grants occur in order 0,1,2,3,0.
- Each grant carries exactly 8 writes.
- Exactly one idle cycle between grants.
REQ-034 Backpressure: force fifo_full for 3 cycles mid-burst.
- No write or ack during those cycles.
- Counter holds; the burst completes at the full length of 8 with no duplicated or lost word.
REQ-035 Reset mid-burst: assert rst low after 4 of 8 words.
- Next cycle: grant=0, busy=0, write_en=0.
- The next grant goes to producer 0.
REQ-036 Wrap: last_owner=3 with producers 1 and 2 requesting SHALL grant 1, then 2.
REQ-037 With FIFO_WRITE_ARB_STATS_EN defined, scenario REQ-034 SHALL yield stall_cnt=3.
